// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data
// memory with a combinational read path.
//   clk, reset            : clock, asynchronous active-high reset
//   pX_req/we/lock/a/wd   : requester beat (X = 0 CPU, X = 1 block engine)
//   pX_gnt                : combinational grant; the beat is taken this cycle
//   pX_rvalid/rd/err      : registered response, one cycle after the grant
//   mem_we/a/wd, mem_rd   : dmem pins
// A port that wins with lock=1 keeps ownership for up to MAX_BURST beats.
// After a burst that is cut off by the limit, the other port is preferred.

// Response register for one port. A granted read captures mem_rd. A granted
// out-of-range beat returns 0 with err set. An in-range write is silent.
module dmem_arbiter_rsp (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_i,
  input  logic        we_i,
  input  logic        oob_i,
  input  logic [31:0] mem_rd_i,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rd_o
);
  logic        rvalid_q, err_q;
  logic [31:0] rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      rvalid_q <= gnt_i && (oob_i || !we_i);
      err_q    <= gnt_i && oob_i;
      if (gnt_i && oob_i)      rd_q <= '0;
      else if (gnt_i && !we_i) rd_q <= mem_rd_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rd_o     = rd_q;
endmodule

module dmem_arbiter #(
  parameter int DEPTH     = 1001,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic        p0_lock,
  input  logic        p1_lock,
  input  logic [31:0] p0_a,
  input  logic [31:0] p1_a,
  input  logic [31:0] p0_wd,
  input  logic [31:0] p1_wd,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rd,
  output logic [31:0] p1_rd,
  output logic        p0_err,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int          NP      = 2;
  localparam int          CW      = $clog2(MAX_BURST + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [CW-1:0] MAXB  = CW'(MAX_BURST);

  logic [NP-1:0]       req, we, lck, gnt, oob, rvalid, err;
  logic [NP-1:0][31:0] a, wd, rd;

  assign req = {p1_req, p0_req};
  assign we  = {p1_we, p0_we};
  assign lck = {p1_lock, p0_lock};
  assign a   = {p1_a, p0_a};
  assign wd  = {p1_wd, p0_wd};

  logic          rr_q, rr_d, locked_q, locked_d, owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cont, any_gnt, gsel;

  // Grant selection. A live lock continuation beats round-robin; reset
  // masks every grant so nothing reaches the memory while it is held.
  always_comb begin
    cont    = locked_q && req[owner_q] && lck[owner_q];
    any_gnt = 1'b0;
    gsel    = 1'b0;
    if (!reset) begin
      if (cont) begin
        any_gnt = 1'b1;
        gsel    = owner_q;
      end else if (req[0] && req[1]) begin
        any_gnt = 1'b1;
        gsel    = rr_q;
      end else if (req[0]) begin
        any_gnt = 1'b1;
        gsel    = 1'b0;
      end else if (req[1]) begin
        any_gnt = 1'b1;
        gsel    = 1'b1;
      end
    end
    gnt = '0;
    if (any_gnt) gnt[gsel] = 1'b1;
  end

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign oob[i] = a[i] >= DEPTH_W;
    dmem_arbiter_rsp u_rsp (
      .clk_i    (clk),
      .rst_i    (reset),
      .gnt_i    (gnt[i]),
      .we_i     (we[i]),
      .oob_i    (oob[i]),
      .mem_rd_i (mem_rd),
      .rvalid_o (rvalid[i]),
      .err_o    (err[i]),
      .rd_o     (rd[i])
    );
  end

  // Out-of-range writes are granted and answered with err, but never
  // reach the memory.
  assign mem_we = any_gnt && we[gsel] && !oob[gsel];
  assign mem_a  = any_gnt ? a[gsel]  : '0;
  assign mem_wd = any_gnt ? wd[gsel] : '0;

  // Arbitration state. Continuations leave the pointer alone unless they hit
  // the burst limit, which hands preference to the waiting port. Anything
  // that is not a continuation ends a lock and follows the normal rule.
  always_comb begin
    rr_d     = rr_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    if (cont) begin
      if (cnt_q + 1'b1 == MAXB) begin
        locked_d = 1'b0;
        cnt_d    = '0;
        rr_d     = ~owner_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      locked_d = 1'b0;
      cnt_d    = '0;
      if (any_gnt) begin
        rr_d = ~gsel;
        if (lck[gsel] && MAX_BURST > 1) begin
          locked_d = 1'b1;
          owner_d  = gsel;
          cnt_d    = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= 1'b0;
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];
  assign p0_rd     = rd[0];
  assign p1_rd     = rd[1];
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter for the single-port data memory. It lets the CPU load/store path (port 0) and a block-transfer engine (port 1) share one `dmem` instance. It supports short locked bursts, checks address range, and registers read data back to the winning requester. It sits between both requesters and the memory's `we`/`a`/`wd`/`rd` pins.

## Interface
- `DEPTH`, 1001: number of valid 32-bit words; legal word addresses are 0..DEPTH-1.
- `MAX_BURST`, 4: maximum consecutive locked beats one port may hold (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request, held until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_lock`, `p1_lock`  in  1  request to keep ownership for the next beat.
- `p0_a`, `p1_a`  in  32  word address.
- `p0_wd`, `p1_wd`  in  32  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; the beat is accepted this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered response valid, one cycle after a granted read or errored beat.
- `p0_rd`, `p1_rd`  out  32  registered read data; 0 on error.
- `p0_err`, `p1_err`  out  1  registered, qualified by rvalid; address ≥ DEPTH.
- `mem_we`  out  1  to dmem `we`.
- `mem_a`  out  32  to dmem `a`.
- `mem_wd`  out  32  to dmem `wd`.
- `mem_rd`  in  32  from dmem `rd` (combinational read).

## Operation
- State: `rr_ptr` (1 bit, next-preferred port), `locked` (1), `owner` (1), `burst_cnt` (range 0..MAX_BURST), response registers per port.
- Lock continuation: if `locked` and `owner` still has req=1 and lock=1, `owner` is granted. This overrides round-robin.
- Otherwise: if only one port requests, it is granted. If both request, port `rr_ptr` is granted. If none request, nothing is granted.
- At most one gnt is high per cycle. gnt is a pure function of the current inputs and registered state.
- Granted beat drives `mem_a`, `mem_wd`, and `mem_we` = pX_we, each from the granted port.
- Out-of-range beat (a ≥ DEPTH): still granted, but `mem_we` is forced 0.
- No grant: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Pointer update on a granted beat that is not a lock continuation: `rr_ptr` becomes the other port.
- Lock continuation beats leave `rr_ptr` unchanged.
- Lock entry: a granted beat with pX_lock=1 while not locked sets `locked`=1, `owner`=X, `burst_cnt`=1.
- Each continuation beat increments `burst_cnt`.
- Lock release, any one of:
  - the owner's granted beat has lock=0;
  - the owner drops req or lock, so there is no continuation;
  - `burst_cnt` reaches MAX_BURST on a granted beat.
- On release by reaching MAX_BURST, `rr_ptr` becomes the non-owner.
- Release by other means uses the normal pointer rule. On any release, `locked`=0 and `burst_cnt`=0.
- MAX_BURST=1 means lock never persists beyond the entry beat.
- Read response:
  - Granted read in range: pX_rd <= `mem_rd` and pX_rvalid <= 1.
  - Granted beat out of range, read or write: pX_rd <= 0, pX_err <= 1, pX_rvalid <= 1.
  - Granted in-range writes produce no response. The write completes at the grant edge.
- rvalid/err are single-cycle pulses. pX_rd holds its last value when rvalid=0.

## Timing
- Grant latency 0: gnt is asserted in the same cycle as req when the port wins.
- Memory write commits on the rising edge that ends the grant cycle.
- Read latency 1: rvalid and rd are valid the cycle after gnt.
- Back-to-back beats: one per cycle, across ports or within a burst. Responses pipeline with no bubbles.
- Worst-case wait for a requester with the other port locked: MAX_BURST cycles.
- Reset (async, active-high) forces:
  - all gnt, rvalid, err = 0 and all rd = 0;
  - `rr_ptr`=0, `locked`=0, `burst_cnt`=0.
- Reset mid-burst drops the lock and any pending response. The first beat after reset follows arbitration from `rr_ptr`=0.
- Simultaneous release and new request: the release cycle's grant is computed from state before release. The other port wins on the following cycle if it requests.

## Test plan
- Reset, then p0 read a=5 with RAM[5]=0xDEADBEEF → p0_gnt=1 in cycle 0; p0_rvalid=1, p0_rd=0xDEADBEEF, p0_err=0 in cycle 1.
- Both ports request continuously, no lock, from reset → grants alternate p0,p1,p0,p1; p0 writes 0x11 to a=2 and p1 reads a=2 after → p1_rd=0x11.
- p0 holds lock with MAX_BURST=4 while p1 requests throughout → p0 granted 4 consecutive cycles, then p1 granted in cycle 5.
- p1 write to a=1001 (DEPTH=1001) → p1_gnt=1, mem_we=0, RAM unchanged; next cycle p1_rvalid=1, p1_err=1, p1_rd=0.
- Assert reset during cycle 2 of a p0 locked burst with p1 waiting → outputs 0 immediately; after release both request → p0 granted first (`rr_ptr`=0), no stale rvalid.
- Idle (no req) → mem_we=0, mem_a=0, no gnt, no rvalid for 10 cycles.
